dispatch_unit: RTL and testbench
================================

Name: dispatch_unit

Overview:
Issue-side counterpart of the result bus selector. Accepts one decoded instruction per cycle over a valid/ready handshake, drives exactly one unit chip select (alu/comp/misc/jmp) with registered operands, and holds misc operations until the misc unit signals done. Sits between the decode stage and the functional units; its chip selects are the same signals that steer result-bus selection.

Parameters:
data_size, 16, operand width
opcode_size, 4, opcode width; [opcode_size-1:opcode_size-2] = unit class, [1:0] = function
misc_timeout, 255, max cycles waiting for misc_done before abort (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  dispatcher can accept this cycle
in_opcode  input  opcode_size  opcode
in_a  input  data_size  operand A
in_b  input  data_size  operand B
misc_done  input  1  misc unit finished current op
alu_cs  output  1  alu selected
comp_cs  output  1  comparator selected
misc_cs  output  1  misc unit selected
jmp_cs  output  1  jump unit selected
op_a  output  data_size  registered operand A
op_b  output  data_size  registered operand B
op_func  output  2  registered opcode[1:0]
misc_err  output  1  one-cycle pulse: misc timeout abort
issue_count  output  16  number of accepted instructions, wraps

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all cs 0; op_a, op_b, op_func 0; misc_err 0; issue_count 0; timeout counter 0. rst wins over every other input, including mid-misc-wait; no cs survives reset.
- Class decode: 00 alu, 01 comp, 10 misc, 11 jmp. Exactly one cs high, or none; never two.
- Accept = in_valid & in_ready at edge N. At N+1: matching cs high, op_a/op_b/op_func hold accepted values, issue_count += 1 (mod 2^16).
- States: IDLE, ISSUE, MISC_WAIT.
- IDLE: in_ready=1. Accept alu/comp/jmp -> ISSUE; accept misc -> MISC_WAIT; no accept -> stay, cs all 0.
- ISSUE: cs high for exactly one cycle per instruction; in_ready=1. Same-cycle accept -> next instruction issues at next cycle (back-to-back, full throughput, cs may stay high across consecutive same-class ops, operands update each cycle). No accept -> IDLE, cs cleared.
- MISC_WAIT: misc_cs held high, operands frozen, timeout counter increments each cycle from 0. in_ready = misc_done. misc_done=1 -> op complete: accept same cycle -> issue next (ISSUE or MISC_WAIT with counter cleared); else IDLE.
- Timeout: counter reaching misc_timeout while misc_done=0 -> IDLE, misc_cs cleared, misc_err pulses one cycle, in_ready=0 that cycle (no accept). misc_done and timeout on same cycle: done wins, no error.
- misc_done outside MISC_WAIT: ignored.
- in_valid=0 never changes operands or counts. Inputs with in_valid=1 but in_ready=0 are not latched; source must hold them.
- in_ready is combinational from state and misc_done only (no in_valid dependency).
- Operands are registered on accept only; stable while cs high.

Test Plan:
- Reset then 3 back-to-back alu ops (opcode 0x1,0x2,0x3, a=1..3): alu_cs high 3 consecutive cycles starting 1 cycle after first accept, op_func 1,2,3, issue_count=3, then alu_cs low.
- Mixed stream alu, comp, jmp (0x0,0x5,0xC): one cs per cycle in order, never two high, in_ready constantly 1.
- Misc op 0x9 (a=0xBEEF), misc_done after 5 cycles, next alu offered throughout: misc_cs high 5 cycles, in_ready low 4 cycles, alu accepted on done cycle, alu_cs the following cycle, op_a frozen at 0xBEEF during wait.
- misc_timeout=8, misc op, no misc_done: misc_cs cleared after 8 wait cycles, misc_err single pulse, returns IDLE, next op accepted; done at the timeout cycle -> no misc_err.
- Assert rst mid MISC_WAIT and during ISSUE: next cycle all cs 0, issue_count 0, in_ready 1.
- 65537 accepted ops: issue_count wraps to 1; stray misc_done pulses in IDLE have no effect.

Source files
------------

// File: rtl/dispatch_unit.sv
// Issue stage: takes one decoded instruction per cycle and drives one unit
// chip select with registered operands; misc ops are held until done or timeout.
module dispatch_unit #(
  parameter int data_size    = 16,
  parameter int opcode_size  = 4,
  parameter int misc_timeout = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [opcode_size-1:0] in_opcode,
  input  logic [data_size-1:0]   in_a,
  input  logic [data_size-1:0]   in_b,
  input  logic                   misc_done,
  output logic                   alu_cs,
  output logic                   comp_cs,
  output logic                   misc_cs,
  output logic                   jmp_cs,
  output logic [data_size-1:0]   op_a,
  output logic [data_size-1:0]   op_b,
  output logic [1:0]             op_func,
  output logic                   misc_err,
  output logic [15:0]            issue_count
);

  localparam int TW = $clog2(misc_timeout + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(misc_timeout - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  localparam logic [1:0] C_ALU  = 2'd0;
  localparam logic [1:0] C_COMP = 2'd1;
  localparam logic [1:0] C_MISC = 2'd2;
  localparam logic [1:0] C_JMP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_MISC
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_cls;
  logic [data_size-1:0] r_a;
  logic [data_size-1:0] r_b;
  logic [1:0]           r_func;
  logic [15:0]          r_cnt;
  logic [TW-1:0]        r_tmo;

  logic [1:0] w_cls;
  logic       w_acc;
  logic       w_tmo;

  assign w_cls = in_opcode[opcode_size-1 -: 2];
  assign w_acc = in_valid & in_ready;

  // done on the last wait cycle takes priority over the abort
  assign w_tmo = (r_state == S_MISC) & ~misc_done
               & (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_acc) begin
      w_next = (w_cls == C_MISC) ? S_MISC : S_ISSUE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_ISSUE: w_next = S_IDLE;
        S_MISC: begin
          if (misc_done | w_tmo) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    alu_cs   = 1'b0;
    comp_cs  = 1'b0;
    misc_cs  = 1'b0;
    jmp_cs   = 1'b0;
    misc_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_ISSUE: begin
        in_ready = 1'b1;
        unique case (1'b1)
          (r_cls == C_ALU):  alu_cs  = 1'b1;
          (r_cls == C_COMP): comp_cs = 1'b1;
          (r_cls == C_MISC): misc_cs = 1'b1;
          (r_cls == C_JMP):  jmp_cs  = 1'b1;
          default: ;
        endcase
      end
      S_MISC: begin
        in_ready = misc_done;
        misc_cs  = 1'b1;
        misc_err = w_tmo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls  <= C_ALU;
      r_a    <= '0;
      r_b    <= '0;
      r_func <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_acc) begin
        r_cls  <= w_cls;
        r_a    <= in_a;
        r_b    <= in_b;
        r_func <= in_opcode[1:0];
        r_cnt  <= r_cnt + 16'd1;
      end
      if ((r_state == S_MISC) && !w_acc) begin
        r_tmo <= r_tmo + TMO_ONE;
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign op_a        = r_a;
  assign op_b        = r_b;
  assign op_func     = r_func;
  assign issue_count = r_cnt;

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: scoreboard of accepted instructions checked
// against the issued chip select and operands, plus per-scenario checks.
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        misc_done = 1'b0;
  logic        alu_cs, comp_cs, misc_cs, jmp_cs;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_func;
  logic        misc_err;
  logic [15:0] issue_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  cs;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  f;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  logic [3:0]  mcs;
  logic [15:0] exp_cnt = '0;
  bit          pend = 0;

  always #5 clk = ~clk;

  dispatch_unit #(
    .data_size(16),
    .opcode_size(4),
    .misc_timeout(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_a(in_a),
    .in_b(in_b),
    .misc_done(misc_done),
    .alu_cs(alu_cs),
    .comp_cs(comp_cs),
    .misc_cs(misc_cs),
    .jmp_cs(jmp_cs),
    .op_a(op_a),
    .op_b(op_b),
    .op_func(op_func),
    .misc_err(misc_err),
    .issue_count(issue_count)
  );

  // Scoreboard: push on accept, pop one cycle later when the issue appears
  always @(negedge clk) begin
    mcs = {alu_cs, comp_cs, misc_cs, jmp_cs};
    tests++;
    if ($countones(mcs) > 1) begin
      fails++;
      $display("FAIL onehot_cs got %b exp at most one high", mcs);
    end
    if (pend) begin
      pend = 0;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_empty got no entry exp one entry");
      end else begin
        me = sbq.pop_front();
        if (mcs !== me.cs || op_a !== me.a || op_b !== me.b ||
            op_func !== me.f || issue_count !== me.cnt) begin
          fails++;
          $display("FAIL sb_issue got cs=%b a=%h b=%h f=%0d n=%0d exp cs=%b a=%h b=%h f=%0d n=%0d",
                   mcs, op_a, op_b, op_func, issue_count,
                   me.cs, me.a, me.b, me.f, me.cnt);
        end
      end
    end
    if (rst) begin
      sbq.delete();
      exp_cnt = '0;
      pend = 0;
    end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      exp_cnt = exp_cnt + 16'd1;
      sbq.push_back({4'b1000 >> in_opcode[3:2], in_a, in_b,
                     in_opcode[1:0], exp_cnt});
      pend = 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] opc,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid  = v;
    in_opcode = opc;
    in_a      = a;
    in_b      = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    tick;
    tick;
    @(negedge clk);
    tests++;
    if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0) begin
      fails++;
      $display("FAIL rst_cs got %b exp 0000", {alu_cs, comp_cs, misc_cs, jmp_cs});
    end
    tests++;
    if (op_a !== 16'h0 || op_b !== 16'h0 || op_func !== 2'd0) begin
      fails++;
      $display("FAIL rst_ops got %h %h %0d exp 0 0 0", op_a, op_b, op_func);
    end
    tests++;
    if (issue_count !== 16'd0 || misc_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_cnt got %0d err=%b exp 0 0", issue_count, misc_err);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'(i), 16'(i), 16'(i * 16));
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready got %b exp 1", in_ready);
      end
      if (i > 1) begin
        tests++;
        if (alu_cs !== 1'b1) begin
          fails++;
          $display("FAIL b2b_alu_cs got %b exp 1", alu_cs);
        end
      end
      tick;
    end
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if (alu_cs !== 1'b1 || op_func !== 2'd3 || issue_count !== 16'd3) begin
      fail_b2b(alu_cs, op_func, issue_count);
    end
    tick;
    @(negedge clk);
    tests++;
    if (alu_cs !== 1'b0 || issue_count !== 16'd3) begin
      fails++;
      $display("FAIL b2b_end got cs=%b n=%0d exp cs=0 n=3", alu_cs, issue_count);
    end
    tick;
  endtask

  task automatic fail_b2b(input logic cs, input logic [1:0] f,
                          input logic [15:0] n);
    fails++;
    $display("FAIL b2b_last got cs=%b f=%0d n=%0d exp cs=1 f=3 n=3", cs, f, n);
  endtask

  task automatic test_mixed;
    logic [3:0] opcs [3];
    opcs[0] = 4'h0;
    opcs[1] = 4'h5;
    opcs[2] = 4'hC;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, opcs[i], 16'(16'h100 + i), 16'(16'h200 + i));
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL mixed_ready got %b exp 1", in_ready);
      end
      tick;
    end
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0001) begin
      fails++;
      $display("FAIL mixed_jmp got %b exp 0001", {alu_cs, comp_cs, misc_cs, jmp_cs});
    end
    tick;
    @(negedge clk);
    tests++;
    if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0000) begin
      fails++;
      $display("FAIL mixed_idle got %b exp 0000", {alu_cs, comp_cs, misc_cs, jmp_cs});
    end
    tick;
  endtask

  task automatic test_misc_wait;
    drive(1'b1, 4'h9, 16'hBEEF, 16'h0F0F);
    tick;
    drive(1'b1, 4'h1, 16'h1234, 16'h5678);
    for (int k = 1; k <= 5; k++) begin
      misc_done = (k == 5);
      @(negedge clk);
      tests++;
      if (misc_cs !== 1'b1 || op_a !== 16'hBEEF || in_ready !== (k == 5)) begin
        fails++;
        $display("FAIL misc_wait%0d got cs=%b a=%h rdy=%b exp cs=1 a=beef rdy=%b",
                 k, misc_cs, op_a, in_ready, (k == 5));
      end
      tick;
    end
    misc_done = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if (alu_cs !== 1'b1 || misc_cs !== 1'b0 || op_a !== 16'h1234) begin
      fails++;
      $display("FAIL misc_next got alu=%b misc=%b a=%h exp 1 0 1234",
               alu_cs, misc_cs, op_a);
    end
    tick;
  endtask

  task automatic test_timeout;
    drive(1'b1, 4'h8, 16'hA5A5, 16'h5A5A);
    tick;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests++;
      if (misc_cs !== 1'b1 || misc_err !== (k == 8) || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL tmo_wait%0d got cs=%b err=%b rdy=%b exp 1 %b 0",
                 k, misc_cs, misc_err, in_ready, (k == 8));
      end
      tick;
    end
    @(negedge clk);
    tests++;
    if (misc_cs !== 1'b0 || misc_err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL tmo_idle got cs=%b err=%b rdy=%b exp 0 0 1",
               misc_cs, misc_err, in_ready);
    end
    drive(1'b1, 4'hD, 16'h0007, 16'h0008);
    tick;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    tests++;
    if (jmp_cs !== 1'b1) begin
      fails++;
      $display("FAIL tmo_after got jmp=%b exp 1", jmp_cs);
    end
    tick;
    drive(1'b1, 4'hA, 16'h1111, 16'h0);
    tick;
    drive(1'b1, 4'hB, 16'h2222, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      misc_done = (k == 8);
      @(negedge clk);
      tests++;
      if (misc_err !== 1'b0 || in_ready !== (k == 8) || op_a !== 16'h1111) begin
        fails++;
        $display("FAIL tmo_done%0d got err=%b rdy=%b a=%h exp 0 %b 1111",
                 k, misc_err, in_ready, op_a, (k == 8));
      end
      tick;
    end
    misc_done = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests++;
      if (misc_cs !== 1'b1 || op_a !== 16'h2222 || misc_err !== (k == 8)) begin
        fails++;
        $display("FAIL tmo_rearm%0d got cs=%b a=%h err=%b exp 1 2222 %b",
                 k, misc_cs, op_a, misc_err, (k == 8));
      end
      tick;
    end
    @(negedge clk);
    tests++;
    if (misc_cs !== 1'b0 || misc_err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_rearm_end got cs=%b err=%b exp 0 0", misc_cs, misc_err);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'h9, 16'h3333, 16'h0);
    tick;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    @(negedge clk);
    tests++;
    if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0 || issue_count !== 16'd0 ||
        in_ready !== 1'b1 || misc_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_misc got cs=%b n=%0d rdy=%b err=%b exp 0000 0 1 0",
               {alu_cs, comp_cs, misc_cs, jmp_cs}, issue_count, in_ready, misc_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 4'h2, 16'h4444, 16'h0001);
    tick;
    drive(1'b1, 4'h3, 16'h5555, 16'h0002);
    rst = 1'b1;
    tick;
    @(negedge clk);
    tests++;
    if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0 || issue_count !== 16'd0 ||
        in_ready !== 1'b1 || op_a !== 16'h0) begin
      fails++;
      $display("FAIL rst_issue got cs=%b n=%0d rdy=%b a=%h exp 0000 0 1 0",
               {alu_cs, comp_cs, misc_cs, jmp_cs}, issue_count, in_ready, op_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    tick;
  endtask

  task automatic test_wrap;
    int r;
    logic [1:0] cls;
    for (int k = 0; k < 6; k++) begin
      misc_done = k[0];
      @(negedge clk);
      tests++;
      if ({alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0 || in_ready !== 1'b1 ||
          issue_count !== 16'd0) begin
        fails++;
        $display("FAIL stray_done got cs=%b rdy=%b n=%0d exp 0000 1 0",
                 {alu_cs, comp_cs, misc_cs, jmp_cs}, in_ready, issue_count);
      end
      tick;
    end
    for (int n = 0; n < 65537; n++) begin
      r = $urandom_range(0, 2);
      cls = (r == 2) ? 2'd3 : 2'(r);
      drive(1'b1, {cls, 2'($urandom_range(0, 3))},
            16'($urandom), 16'($urandom));
      misc_done = 1'($urandom_range(0, 1));
      tick;
    end
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    misc_done = 1'b0;
    @(negedge clk);
    tests++;
    if (issue_count !== 16'd1) begin
      fails++;
      $display("FAIL wrap_count got %0d exp 1", issue_count);
    end
    tick;
    @(negedge clk);
    tests++;
    if (issue_count !== 16'd1 || {alu_cs, comp_cs, misc_cs, jmp_cs} !== 4'b0) begin
      fails++;
      $display("FAIL wrap_idle got n=%0d cs=%b exp 1 0000",
               issue_count, {alu_cs, comp_cs, misc_cs, jmp_cs});
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_mixed;
    test_misc_wait;
    test_timeout;
    test_reset_mid;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
